// File: rtl/ervp_apb_initiator.sv
`timescale 1ns/1ps
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns read data and error/timeout status on a response channel.
module ervp_apb_initiator #(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 32,
  parameter int TIMEOUT    = 256,
  parameter int BW_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BW_ADDR-1:0] req_addr,
  input  logic               req_write,
  input  logic [BW_DATA-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BW_DATA-1:0] rsp_rdata,
  output logic               rsp_slverr,
  output logic               rsp_timeout,
  output logic               spsel,
  output logic               spenable,
  output logic [BW_ADDR-1:0] spaddr,
  output logic               spwrite,
  output logic [BW_DATA-1:0] spwdata,
  input  logic [BW_DATA-1:0] sprdata,
  input  logic               spready,
  input  logic               spslverr,
  output logic               busy
);

  if ((TIMEOUT < 0) || (64'(TIMEOUT) >= (64'd1 << BW_TIMEOUT))) begin : g_bad_timeout
    $error("TIMEOUT must be non-negative and fit in BW_TIMEOUT bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam bit                    WDT_EN   = (TIMEOUT != 0);
  localparam logic [BW_TIMEOUT-1:0] WDT_LAST = (TIMEOUT == 0) ? '0 : BW_TIMEOUT'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  spsel_q, spsel_d;
  logic                  spenable_q, spenable_d;
  logic [BW_ADDR-1:0]    spaddr_q, spaddr_d;
  logic                  spwrite_q, spwrite_d;
  logic [BW_DATA-1:0]    spwdata_q, spwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [BW_DATA-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [BW_TIMEOUT-1:0] wdt_q, wdt_d;
  logic                  to_resp;

  // Saturating increment: the watchdog must never wrap back to zero.
  function automatic logic [BW_TIMEOUT-1:0] wdt_inc(input logic [BW_TIMEOUT-1:0] cnt);
    if (cnt == {BW_TIMEOUT{1'b1}}) begin
      wdt_inc = cnt;
    end else begin
      wdt_inc = cnt + BW_TIMEOUT'(1);
    end
  endfunction

  always_comb begin
    state_d       = state_q;
    spsel_d       = spsel_q;
    spenable_d    = spenable_q;
    spaddr_d      = spaddr_q;
    spwrite_d     = spwrite_q;
    spwdata_d     = spwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    wdt_d         = wdt_q;
    to_resp       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          spaddr_d  = req_addr;
          spwrite_d = req_write;
          spwdata_d = req_wdata;
          spsel_d   = 1'b1;
          wdt_d     = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        spenable_d = 1'b1;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        // spready takes priority over a watchdog expiring in the same cycle
        if (spready) begin
          rsp_rdata_d   = spwrite_q ? '0 : sprdata;
          rsp_slverr_d  = spslverr;
          rsp_timeout_d = 1'b0;
          to_resp       = 1'b1;
        end else if (WDT_EN) begin
          if (wdt_q == WDT_LAST) begin
            rsp_rdata_d   = '0;
            rsp_slverr_d  = 1'b0;
            rsp_timeout_d = 1'b1;
            to_resp       = 1'b1;
          end else begin
            wdt_d = wdt_inc(wdt_q);
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (to_resp) begin
      spsel_d     = 1'b0;
      spenable_d  = 1'b0;
      spaddr_d    = '0;
      spwrite_d   = 1'b0;
      spwdata_d   = '0;
      rsp_valid_d = 1'b1;
      state_d     = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q       <= ST_IDLE;
      spsel_q       <= 1'b0;
      spenable_q    <= 1'b0;
      spaddr_q      <= '0;
      spwrite_q     <= 1'b0;
      spwdata_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wdt_q         <= '0;
    end else begin
      state_q       <= state_d;
      spsel_q       <= spsel_d;
      spenable_q    <= spenable_d;
      spaddr_q      <= spaddr_d;
      spwrite_q     <= spwrite_d;
      spwdata_q     <= spwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      wdt_q         <= wdt_d;
    end
  end

  // req_ready and busy follow the state only, never req_valid
  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign spsel       = spsel_q;
  assign spenable    = spenable_q;
  assign spaddr      = spaddr_q;
  assign spwrite     = spwrite_q;
  assign spwdata     = spwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_ervp_apb_initiator.sv
`timescale 1ns/1ps
// Directed bench for ervp_apb_initiator with an 8-cycle watchdog and a
// hand-driven APB responder.
module tb_ervp_apb_initiator;

  logic        clk = 1'b0;
  logic        rstnn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic        spsel;
  logic        spenable;
  logic [31:0] spaddr;
  logic        spwrite;
  logic [31:0] spwdata;
  logic [31:0] sprdata;
  logic        spready;
  logic        spslverr;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  ervp_apb_initiator #(
    .BW_ADDR(32), .BW_DATA(32), .TIMEOUT(8), .BW_TIMEOUT(16)
  ) dut (
    .clk(clk), .rstnn(rstnn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .spsel(spsel), .spenable(spenable), .spaddr(spaddr), .spwrite(spwrite),
    .spwdata(spwdata), .sprdata(sprdata), .spready(spready), .spslverr(spslverr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang, expected $finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command from IDLE; the responder raises spready on ACCESS cycle
  // ready_at (0 = never) and drives junk on every other cycle.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input int ready_at, input logic [31:0] rd, input logic err,
                      output int en_cyc, output int lat);
    int it;
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    spready = 1'b0; spslverr = 1'b0;
    tick();
    req_valid = 1'b0;
    en_cyc = 0;
    it = 0;
    while (it < 40 && !rsp_valid) begin
      if (spenable) en_cyc++;
      if (spenable && en_cyc == ready_at) begin
        spready = 1'b1; sprdata = rd; spslverr = err;
      end else begin
        spready = !spenable; sprdata = 32'hA5A5_0000 ^ 32'(it); spslverr = 1'b1;
      end
      tick();
      it++;
    end
    spready = 1'b0; spslverr = 1'b0;
    lat = it + 1;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk1("ack_rsp_valid_low", rsp_valid, 1'b0);
  endtask

  initial begin
    int en_cyc, lat, n_setup, first_setup, second_setup;
    rstnn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; sprdata = '0; spready = 1'b0; spslverr = 1'b0;
    tick(); tick();

    chk1("rst_spsel", spsel, 1'b0);
    chk1("rst_spenable", spenable, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk32("rst_spaddr", spaddr, 32'h0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    rstnn = 1'b1;
    tick();

    // zero-wait write, spready high even during SETUP
    req_valid = 1'b1; req_addr = 32'h10; req_write = 1'b1; req_wdata = 32'hDEADBEEF;
    spready = 1'b1; sprdata = 32'hAAAA5555; spslverr = 1'b0;
    chk1("w_req_ready_idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFF0; req_wdata = 32'h0;
    chk1("w_setup_spsel", spsel, 1'b1);
    chk1("w_setup_spenable", spenable, 1'b0);
    chk32("w_setup_spaddr", spaddr, 32'h10);
    chk32("w_setup_spwdata", spwdata, 32'hDEADBEEF);
    chk1("w_setup_spwrite", spwrite, 1'b1);
    chk1("w_setup_busy", busy, 1'b1);
    chk1("w_setup_req_ready", req_ready, 1'b0);
    chk1("w_setup_rsp_valid", rsp_valid, 1'b0);
    tick();
    chk1("w_access_spsel", spsel, 1'b1);
    chk1("w_access_spenable", spenable, 1'b1);
    chk32("w_access_spaddr", spaddr, 32'h10);
    chk32("w_access_spwdata", spwdata, 32'hDEADBEEF);
    chk1("w_access_rsp_valid", rsp_valid, 1'b0);
    tick();
    spready = 1'b0;
    chk1("w_resp_rsp_valid", rsp_valid, 1'b1);
    chk32("w_resp_rdata", rsp_rdata, 32'h0);
    chk1("w_resp_slverr", rsp_slverr, 1'b0);
    chk1("w_resp_timeout", rsp_timeout, 1'b0);
    chk1("w_resp_spsel", spsel, 1'b0);
    chk1("w_resp_spenable", spenable, 1'b0);
    chk32("w_resp_spaddr", spaddr, 32'h0);
    chk32("w_resp_spwdata", spwdata, 32'h0);
    ack();
    chk1("w_idle_busy", busy, 1'b0);
    chk1("w_idle_req_ready", req_ready, 1'b1);

    // read with three wait states
    xfer(32'h04, 1'b0, 32'h0, 4, 32'h12345678, 1'b0, en_cyc, lat);
    chkn("r_ws_enable_cycles", en_cyc, 4);
    chkn("r_ws_latency", lat, 6);
    chk1("r_ws_rsp_valid", rsp_valid, 1'b1);
    chk32("r_ws_rdata", rsp_rdata, 32'h12345678);
    chk1("r_ws_slverr", rsp_slverr, 1'b0);
    chk1("r_ws_timeout", rsp_timeout, 1'b0);
    ack();

    // slave error, then a clean transfer clears it
    xfer(32'h08, 1'b0, 32'h0, 1, 32'hCAFE0001, 1'b1, en_cyc, lat);
    chkn("err_latency", lat, 3);
    chk1("err_slverr", rsp_slverr, 1'b1);
    chk1("err_timeout", rsp_timeout, 1'b0);
    chk32("err_rdata", rsp_rdata, 32'hCAFE0001);
    ack();
    xfer(32'h0C, 1'b1, 32'h0000_0077, 1, 32'h0, 1'b0, en_cyc, lat);
    chk1("after_err_slverr", rsp_slverr, 1'b0);
    chk32("after_err_rdata", rsp_rdata, 32'h0);
    ack();

    // watchdog expiry with spready never asserted
    xfer(32'h30, 1'b0, 32'h0, 0, 32'h0, 1'b0, en_cyc, lat);
    chkn("to_enable_cycles", en_cyc, 8);
    chkn("to_latency", lat, 10);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_timeout", rsp_timeout, 1'b1);
    chk1("to_slverr", rsp_slverr, 1'b0);
    chk32("to_rdata", rsp_rdata, 32'h0);
    chk1("to_spsel", spsel, 1'b0);
    ack();
    chk1("to_cleared_timeout", rsp_timeout, 1'b0);

    // spready rises on the last watchdog cycle
    xfer(32'h34, 1'b0, 32'h0, 8, 32'h0BAD_F00D, 1'b0, en_cyc, lat);
    chkn("edge_enable_cycles", en_cyc, 8);
    chk1("edge_timeout", rsp_timeout, 1'b0);
    chk32("edge_rdata", rsp_rdata, 32'h0BAD_F00D);
    ack();

    // response held while rsp_ready stays low
    req_valid = 1'b1; req_addr = 32'h20; req_write = 1'b0;
    spready = 1'b1; sprdata = 32'h5555AAAA;
    tick(); tick(); tick();
    req_addr = 32'h40; req_write = 1'b1; req_wdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      sprdata = 32'h9999_0000 ^ 32'(i);
      chk1("hold_rsp_valid", rsp_valid, 1'b1);
      chk32("hold_rdata", rsp_rdata, 32'h5555AAAA);
      chk1("hold_req_ready", req_ready, 1'b0);
      chk1("hold_spsel", spsel, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk1("hold_release_spsel", spsel, 1'b0);
    chk1("hold_release_req_ready", req_ready, 1'b1);

    // back-to-back with rsp_ready tied high
    n_setup = 0; first_setup = -1; second_setup = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (spsel && !spenable) begin
        n_setup++;
        if (first_setup < 0) first_setup = i;
        else if (second_setup < 0) second_setup = i;
      end
    end
    req_valid = 1'b0; spready = 1'b0; rsp_ready = 1'b0;
    chkn("b2b_setup_count", n_setup, 3);
    chkn("b2b_first_setup", first_setup, 1);
    chkn("b2b_interval", second_setup - first_setup, 4);
    chk1("b2b_idle_busy", busy, 1'b0);

    // reset during ACCESS abandons the transfer
    req_valid = 1'b1; req_addr = 32'h50; req_write = 1'b1; req_wdata = 32'h0000_600D;
    spready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk1("rstmid_access_spenable", spenable, 1'b1);
    rstnn = 1'b0;
    tick();
    chk1("rstmid_spsel", spsel, 1'b0);
    chk1("rstmid_spenable", spenable, 1'b0);
    chk1("rstmid_rsp_valid", rsp_valid, 1'b0);
    chk1("rstmid_busy", busy, 1'b0);
    chk32("rstmid_spaddr", spaddr, 32'h0);
    rstnn = 1'b1;
    tick();
    chk1("rstmid_req_ready", req_ready, 1'b1);
    chk1("rstmid_no_rsp", rsp_valid, 1'b0);
    xfer(32'h24, 1'b1, 32'h0000_BEEF, 1, 32'h0, 1'b0, en_cyc, lat);
    chkn("rstmid_w_latency", lat, 3);
    chk1("rstmid_w_rsp_valid", rsp_valid, 1'b1);
    chk1("rstmid_w_slverr", rsp_slverr, 1'b0);
    chk1("rstmid_w_timeout", rsp_timeout, 1'b0);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
